// File: rtl/code_entry_collector_if.sv
// code_entry_collector_if
//   Groups the digit-entry handshake between the entry handler (master) and
//   the code collector (slave).
//   master -> slave : digit_in, store_digit_pulse, increment_counter_pulse,
//                     clear_code
//   slave -> master : enable_entry, code_value, digit_count, code_ready,
//                     digit_blank, reject_pulse, protocol_error, timeout_pulse
interface code_entry_collector_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic [DIGIT_W-1:0]            digit_in;
  logic                          store_digit_pulse;
  logic                          increment_counter_pulse;
  logic                          clear_code;

  logic                          enable_entry;
  logic [NUM_DIGITS*DIGIT_W-1:0] code_value;
  logic [CNT_W-1:0]              digit_count;
  logic                          code_ready;
  logic [NUM_DIGITS-1:0]         digit_blank;
  logic                          reject_pulse;
  logic                          protocol_error;
  logic                          timeout_pulse;

  modport master (
    output digit_in, store_digit_pulse, increment_counter_pulse, clear_code,
    input  enable_entry, code_value, digit_count, code_ready, digit_blank,
           reject_pulse, protocol_error, timeout_pulse
  );

  modport slave (
    input  digit_in, store_digit_pulse, increment_counter_pulse, clear_code,
    output enable_entry, code_value, digit_count, code_ready, digit_blank,
           reject_pulse, protocol_error, timeout_pulse
  );
endinterface

// File: rtl/code_entry_collector.sv
// code_entry_collector
//   Collects BCD digits into a NUM_DIGITS-wide code register. A digit is taken
//   when store_digit_pulse and increment_counter_pulse arrive together; the
//   newest digit lands in the least significant position. When the code is
//   complete, code_ready rises and enable_entry falls until clear_code. A
//   partial code left idle for TIMEOUT_CYCLES cycles is abandoned.
// Ports
//   clk        system clock
//   sys_reset  asynchronous, active-high reset (released synchronously
//              upstream)
//   bus        code_entry_collector_if.slave (digit input, pulses, clear,
//              and all registered status outputs)
module code_entry_collector #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   sys_reset,
  code_entry_collector_if.slave  bus
);

  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);
  localparam int CODE_W = NUM_DIGITS * DIGIT_W;

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    COLLECTING = 2'd1,
    FULL       = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [CODE_W-1:0]    code_reg, code_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [TMR_W-1:0]     timer_reg, timer_next;
  logic                 perr_reg, perr_next;
  logic                 reject_reg, reject_next;
  logic                 timeout_reg, timeout_next;
  logic                 ready_reg;
  logic                 enable_reg;
  logic [NUM_DIGITS-1:0] blank_reg, blank_next;

  logic                 pair;
  logic                 unpaired;
  logic                 is_bcd;
  logic                 accept;
  logic                 expire;
  logic [CODE_W-1:0]    code_shifted;

  assign pair     = bus.store_digit_pulse & bus.increment_counter_pulse;
  assign unpaired = bus.store_digit_pulse ^ bus.increment_counter_pulse;
  assign is_bcd   = (bus.digit_in <= DIGIT_W'(9));
  assign accept   = pair && is_bcd && (state_reg != FULL);
  assign expire   = (state_reg == COLLECTING) &&
                    (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));

  // Single-digit codes have no upper field to keep.
  generate
    if (NUM_DIGITS > 1) begin : g_shift_multi
      assign code_shifted = {code_reg[(NUM_DIGITS-1)*DIGIT_W-1:0], bus.digit_in};
    end else begin : g_shift_single
      assign code_shifted = bus.digit_in;
    end
  endgenerate

  // Next-state and next-output logic. Priority: clear, accepted pair,
  // timeout expiry, then rejection of anything else. A timeout behaves like
  // clear_code, so a bad pulse in the expiry cycle is dropped silently.
  always_comb begin
    state_next   = state_reg;
    code_next    = code_reg;
    count_next   = count_reg;
    timer_next   = timer_reg;
    perr_next    = perr_reg;
    reject_next  = 1'b0;
    timeout_next = 1'b0;

    if (bus.clear_code) begin
      state_next = EMPTY;
      code_next  = '0;
      count_next = '0;
      timer_next = '0;
      perr_next  = 1'b0;
    end else if (accept) begin
      code_next  = code_shifted;
      count_next = count_reg + CNT_W'(1);
      timer_next = '0;
      state_next = (count_reg == CNT_W'(NUM_DIGITS - 1)) ? FULL : COLLECTING;
    end else if (expire) begin
      state_next   = EMPTY;
      code_next    = '0;
      count_next   = '0;
      timer_next   = '0;
      perr_next    = 1'b0;
      timeout_next = 1'b1;
    end else begin
      // FULL swallows every pulse without comment.
      if (state_reg != FULL) begin
        if (pair) begin
          reject_next = 1'b1;
        end else if (unpaired) begin
          reject_next = 1'b1;
          perr_next   = 1'b1;
        end
      end
      // Cannot wrap: expiry at TIMEOUT_CYCLES-1 is handled above.
      if (state_reg == COLLECTING) begin
        timer_next = timer_reg + TMR_W'(1);
      end
    end
  end

  // Blanking mask follows the count being registered, so the mask and
  // code_value change on the same edge.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      assign blank_next[gi] = (CNT_W'(gi) >= count_next);
    end
  endgenerate

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_reg   <= EMPTY;
      code_reg    <= '0;
      count_reg   <= '0;
      timer_reg   <= '0;
      perr_reg    <= 1'b0;
      reject_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      ready_reg   <= 1'b0;
      enable_reg  <= 1'b1;
      blank_reg   <= '1;
    end else begin
      state_reg   <= state_next;
      code_reg    <= code_next;
      count_reg   <= count_next;
      timer_reg   <= timer_next;
      perr_reg    <= perr_next;
      reject_reg  <= reject_next;
      timeout_reg <= timeout_next;
      ready_reg   <= (state_next == FULL);
      enable_reg  <= (state_next != FULL);
      blank_reg   <= blank_next;
    end
  end

  assign bus.enable_entry   = enable_reg;
  assign bus.code_value     = code_reg;
  assign bus.digit_count    = count_reg;
  assign bus.code_ready     = ready_reg;
  assign bus.digit_blank    = blank_reg;
  assign bus.reject_pulse   = reject_reg;
  assign bus.protocol_error = perr_reg;
  assign bus.timeout_pulse  = timeout_reg;

endmodule

// File: tb/tb_code_entry_collector.sv
// tb_code_entry_collector
//   Drives code_entry_collector through directed scenarios and random traffic
//   and compares every output each cycle against a queue-based model of the
//   collected code.
module tb_code_entry_collector;

  localparam int N = 4;
  localparam int W = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic sys_reset;

  always #5 clk = ~clk;

  code_entry_collector_if #(.NUM_DIGITS(N), .DIGIT_W(W)) bus ();

  code_entry_collector #(
    .NUM_DIGITS(N),
    .DIGIT_W(W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .sys_reset(sys_reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Model: the code is simply the list of accepted digits.
  int m_digits[$];
  bit m_perr;
  int m_idle;
  bit m_reject;
  bit m_timeout;

  function automatic void model_reset();
    m_digits.delete();
    m_perr    = 0;
    m_idle    = 0;
    m_reject  = 0;
    m_timeout = 0;
  endfunction

  function automatic void model_step(bit st, bit inc, int d, bit clr);
    bit full;
    full      = (m_digits.size() == N);
    m_reject  = 0;
    m_timeout = 0;
    if (clr) begin
      m_digits.delete();
      m_perr = 0;
      m_idle = 0;
    end else if (!full) begin
      if (st && inc && d <= 9) begin
        m_digits.push_back(d);
        m_idle = 0;
      end else if (m_digits.size() > 0 && m_idle == T - 1) begin
        m_digits.delete();
        m_perr    = 0;
        m_idle    = 0;
        m_timeout = 1;
      end else begin
        if (st || inc) begin
          m_reject = 1;
          if (st != inc) m_perr = 1;
        end
        if (m_digits.size() > 0) m_idle++;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [63:0] exp_code;
    logic [63:0] exp_blank;
    bit          ready;
    exp_code  = 0;
    exp_blank = 0;
    foreach (m_digits[i]) exp_code = (exp_code << W) | 64'(m_digits[i]);
    for (int i = 0; i < N; i++) exp_blank[i] = (i >= m_digits.size());
    ready = (m_digits.size() == N);
    check_eq({tag, ".code"},    64'(bus.code_value),     exp_code);
    check_eq({tag, ".count"},   64'(bus.digit_count),    64'(m_digits.size()));
    check_eq({tag, ".ready"},   64'(bus.code_ready),     64'(ready));
    check_eq({tag, ".enable"},  64'(bus.enable_entry),   64'(!ready));
    check_eq({tag, ".blank"},   64'(bus.digit_blank),    exp_blank);
    check_eq({tag, ".reject"},  64'(bus.reject_pulse),   64'(m_reject));
    check_eq({tag, ".perr"},    64'(bus.protocol_error), 64'(m_perr));
    check_eq({tag, ".timeout"}, 64'(bus.timeout_pulse),  64'(m_timeout));
  endtask

  // One clock of stimulus; called just after a falling edge, checks at the
  // next falling edge.
  task automatic do_cycle(input string tag, input bit st, input bit inc, input int d, input bit clr);
    bus.store_digit_pulse       = st;
    bus.increment_counter_pulse = inc;
    bus.digit_in                = W'(d);
    bus.clear_code              = clr;
    model_step(st, inc, d, clr);
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t %s st=%0b inc=%0b d=%0d clr=%0b -> code=%h cnt=%0d rdy=%0b en=%0b blank=%b rej=%0b perr=%0b tmo=%0b",
             $time, tag, st, inc, d, clr, bus.code_value, bus.digit_count, bus.code_ready,
             bus.enable_entry, bus.digit_blank, bus.reject_pulse, bus.protocol_error,
             bus.timeout_pulse);
    compare_all(tag);
    bus.store_digit_pulse       = 1'b0;
    bus.increment_counter_pulse = 1'b0;
    bus.clear_code              = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) do_cycle(tag, 0, 0, 0, 0);
  endtask

  initial begin
    int r;
    sys_reset                   = 1'b1;
    bus.digit_in                = '0;
    bus.store_digit_pulse       = 1'b0;
    bus.increment_counter_pulse = 1'b0;
    bus.clear_code              = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    sys_reset = 1'b0;
    idle("post_reset", 2);

    // Four digits, five cycles apart.
    for (int d = 1; d <= 4; d++) begin
      do_cycle("pair", 1, 1, d, 0);
      if (d == 4) begin
        check_eq("ready_after_4th", 64'(bus.code_ready), 64'd1);
        check_eq("enable_after_4th", 64'(bus.enable_entry), 64'd0);
      end
      idle("gap", 4);
    end
    check_eq("code_1234", 64'(bus.code_value), 64'h1234);
    check_eq("blank_full", 64'(bus.digit_blank), 64'h0);

    // FULL ignores pulses; clear beats a simultaneous pair.
    do_cycle("full_pair9", 1, 1, 9, 0);
    check_eq("full_hold", 64'(bus.code_value), 64'h1234);
    check_eq("full_no_reject", 64'(bus.reject_pulse), 64'd0);
    do_cycle("full_store_only", 1, 0, 2, 0);
    check_eq("full_no_perr", 64'(bus.protocol_error), 64'd0);
    do_cycle("clear_with_pair", 1, 1, 5, 1);
    check_eq("clear_count", 64'(bus.digit_count), 64'd0);
    check_eq("clear_enable", 64'(bus.enable_entry), 64'd1);

    // Non-BCD digit.
    do_cycle("pair7", 1, 1, 7, 0);
    do_cycle("pairA", 1, 1, 10, 0);
    check_eq("nonbcd_reject", 64'(bus.reject_pulse), 64'd1);
    check_eq("nonbcd_code", 64'(bus.code_value), 64'h7);
    check_eq("nonbcd_perr", 64'(bus.protocol_error), 64'd0);
    idle("after_nonbcd", 1);
    check_eq("reject_one_cycle", 64'(bus.reject_pulse), 64'd0);

    // Unpaired pulses.
    do_cycle("inc_only", 0, 1, 0, 0);
    check_eq("perr_set", 64'(bus.protocol_error), 64'd1);
    do_cycle("store_only5", 1, 0, 5, 0);
    check_eq("perr_held", 64'(bus.protocol_error), 64'd1);
    check_eq("unpaired_count", 64'(bus.digit_count), 64'd1);
    do_cycle("clear", 0, 0, 0, 1);
    check_eq("perr_cleared", 64'(bus.protocol_error), 64'd0);

    // Timeout after one digit.
    do_cycle("pair3", 1, 1, 3, 0);
    idle("idle_to_expiry", 15);
    check_eq("no_timeout_early", 64'(bus.timeout_pulse), 64'd0);
    do_cycle("expiry", 0, 0, 0, 0);
    check_eq("timeout_fired", 64'(bus.timeout_pulse), 64'd1);
    check_eq("timeout_blank", 64'(bus.digit_blank), 64'hF);
    idle("after_timeout", 1);

    // Pair on the expiry cycle wins.
    do_cycle("pair3b", 1, 1, 3, 0);
    idle("idle_to_expiry_b", 15);
    do_cycle("pair_on_expiry", 1, 1, 5, 0);
    check_eq("expiry_pair_count", 64'(bus.digit_count), 64'd2);
    check_eq("expiry_pair_no_timeout", 64'(bus.timeout_pulse), 64'd0);

    // Asynchronous reset mid-cycle with a partial code and pending pulses.
    do_cycle("clear2", 0, 0, 0, 1);
    do_cycle("pair8", 1, 1, 8, 0);
    do_cycle("pair6", 1, 1, 6, 0);
    do_cycle("store_only_pre_rst", 1, 0, 1, 0);
    #2;
    sys_reset = 1'b1;
    model_reset();
    #1;
    compare_all("async_reset");
    @(negedge clk);
    sys_reset = 1'b0;
    idle("post_async_reset", 1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       do_cycle("rnd_clear", $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 11), 1);
      else if (r < 45) do_cycle("rnd_pair", 1, 1, $urandom_range(0, 11), 0);
      else if (r < 50) do_cycle("rnd_store", 1, 0, $urandom_range(0, 11), 0);
      else if (r < 55) do_cycle("rnd_inc", 0, 1, $urandom_range(0, 11), 0);
      else if (r < 58) idle("rnd_burst", $urandom_range(14, 18));
      else             idle("rnd_idle", 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/code_entry_collector.md
Name: code_entry_collector

Overview:
- Downstream end of the digit-entry path. Consumes the paired one-cycle store_digit_pulse / increment_counter_pulse from the entry handler.
- Shifts the current BCD digit into a multi-digit code register and counts accepted digits.
- Asserts code_ready when the code is complete and drives enable_entry back to the entry handler to close the loop.
- Provides a blanking mask for the display and an inactivity timeout that abandons partial codes.

Parameters:
- NUM_DIGITS, 4, digits per code (2..8).
- DIGIT_W, 4, bits per digit (BCD).
- TIMEOUT_CYCLES, 50_000_000, idle cycles in COLLECTING before auto-clear (≥2).

Ports:
- clk  in  1  system clock.
- sys_reset  in  1  asynchronous, active-high reset.
- digit_in  in  DIGIT_W  current digit from switches; sampled on store_digit_pulse.
- store_digit_pulse  in  1  one-cycle shift request.
- increment_counter_pulse  in  1  one-cycle count request.
- clear_code  in  1  synchronous clear from the safe FSM (after compare or user cancel).
- enable_entry  out  1  1 = collector accepts digits; feeds the entry handler.
- code_value  out  NUM_DIGITS*DIGIT_W  collected code; newest digit in bits [DIGIT_W-1:0].
- digit_count  out  clog2(NUM_DIGITS+1)  accepted digits, 0..NUM_DIGITS.
- code_ready  out  1  level; 1 while the code is complete (state FULL).
- digit_blank  out  NUM_DIGITS  bit i = 1 when display position i is unfilled (i ≥ digit_count).
- reject_pulse  out  1  one-cycle; digit rejected (non-BCD or protocol mismatch).
- protocol_error  out  1  sticky; an unpaired pulse was seen.
- timeout_pulse  out  1  one-cycle; inactivity auto-clear occurred.

Behaviour:
- Reset (async assert, sync release) sets:
  - state EMPTY, code_value 0, digit_count 0, code_ready 0, enable_entry 1, digit_blank all 1s.
  - reject_pulse 0, protocol_error 0, timeout_pulse 0, timer 0.
- All outputs are registered. An event sampled at edge N appears after edge N (1-cycle latency).
- Accepted pair: store and increment both high in the same cycle, state EMPTY or COLLECTING, and digit_in ≤ 9.
  - code_value <= {code_value[(NUM_DIGITS-1)*DIGIT_W-1:0], digit_in}.
  - digit_count +1; idle timer cleared.
- Non-BCD digit (digit_in > 9) on a pair: no shift, no count change, reject_pulse for 1 cycle. protocol_error is unaffected.
- Unpaired pulse (exactly one of store/increment high), in EMPTY or COLLECTING:
  - No shift, no count change.
  - reject_pulse for 1 cycle; protocol_error set and held until clear_code or reset.
- States:
  - EMPTY: count 0. An accepted pair goes to COLLECTING, or directly to FULL if NUM_DIGITS = 1 (not a legal parameter value; the rule covers it anyway).
  - COLLECTING: the accepted pair that makes count = NUM_DIGITS goes to FULL. Otherwise stay.
  - FULL: code_ready = 1 and enable_entry = 0, both registered in the same update as the final count. All pulses are ignored silently (no reject, no error). Stay until clear_code.
- clear_code (any state):
  - Next cycle: EMPTY, code 0, count 0, protocol_error 0, timer 0, enable_entry 1.
  - clear_code has priority over a simultaneous pulse; that pulse is dropped with no reject.
- Timeout:
  - The timer counts only in COLLECTING and resets on every accepted pair.
  - When the timer reaches TIMEOUT_CYCLES-1 with no event: behave as clear_code and emit timeout_pulse for 1 cycle.
  - An accepted pair in the same cycle as expiry wins; no timeout.
  - Timer width is clog2(TIMEOUT_CYCLES); it never wraps.
- digit_blank is derived from the registered digit_count and kept registered, so it is coherent with code_value on the same cycle.
- Reset mid-collection: immediate return to reset values; no pulses emitted.

Test Plan:
- Reset, then pairs with digit_in 1,2,3,4 spaced 5 cycles apart -> code_value 0x1234, digit_count 4, code_ready 1 and enable_entry 0 one cycle after the 4th pair, digit_blank 4'b0000.
- Pair with digit_in 0xA after digit 7 -> reject_pulse for one cycle, code_value 0x0007, count 1, protocol_error 0.
- store only (increment low) with digit_in 5 in COLLECTING -> reject_pulse 1 cycle, protocol_error stays 1, code and count unchanged. A following clear_code drives protocol_error to 0.
- In FULL, a pair with digit_in 9 -> no change to 0x1234, no reject. clear_code with a simultaneous pair -> next cycle count 0, code 0, enable_entry 1.
- TIMEOUT_CYCLES=16, one pair with digit_in 3 then idle -> 16 cycles later timeout_pulse for 1 cycle, state EMPTY, digit_blank 4'b1111. A pair on the expiry cycle -> count 2, no timeout.
- Assert sys_reset asynchronously mid-cycle after 2 digits -> outputs go to reset values before the next clk edge.
